// File: rtl/psum_acc_buf_pkg.sv
// psum_acc_buf_pkg: shared widths and FSM state encoding for the psum
// accumulation buffer and the stages that reuse its requantizer.
//   IFMAP_WID / WEIGHT_WID : operand widths feeding the PE_vec row
//   PSUM_WID               : PE_vec partial-sum width
//   ACC_WID                : accumulator width
//   OFMAP_WID              : requantized ofmap width
//   state_e                : ST_ACCUM / ST_DRAIN

package psum_acc_buf_pkg;

    localparam int IFMAP_WID  = 8;
    localparam int WEIGHT_WID = 8;
    localparam int PSUM_WID   = IFMAP_WID + WEIGHT_WID;
    localparam int ACC_WID    = 24;
    localparam int OFMAP_WID  = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/psum_acc_buf_if.sv
// psum_acc_buf_if: psum input stream, ofmap output stream and group_done
// pulse of the psum accumulation buffer.
//   slave  : the buffer side (consumes psum, produces ofmap)
//   master : the neighbour side (PE_vec row + ofmap writeback)

interface psum_acc_buf_if #(
    parameter int PSUM_WID = psum_acc_buf_pkg::PSUM_WID,
    parameter int OUT_WID  = psum_acc_buf_pkg::OFMAP_WID
);
    logic signed [PSUM_WID-1:0] psum_in;
    logic                       psum_valid;
    logic                       psum_ready;
    logic signed [OUT_WID-1:0]  ofmap_out;
    logic                       ofmap_valid;
    logic                       ofmap_ready;
    logic                       group_done;

    modport slave (
        input  psum_in, psum_valid, ofmap_ready,
        output psum_ready, ofmap_out, ofmap_valid, group_done
    );

    modport master (
        output psum_in, psum_valid, ofmap_ready,
        input  psum_ready, ofmap_out, ofmap_valid, group_done
    );
endinterface

// File: rtl/psum_acc_buf_quant.sv
// psum_quant: combinational requantizer, arithmetic right shift by SHIFT
// (floor toward -inf) then saturation to the signed OUT_WID range.
// With PSUM_ACC_RELU_EN defined, negative saturated results become 0.
//   acc_i : signed ACC_WID accumulator value
//   q_o   : signed OUT_WID result

module psum_quant
    import psum_acc_buf_pkg::*;
#(
    parameter int ACC_WID = psum_acc_buf_pkg::ACC_WID,
    parameter int SHIFT   = 0,
    parameter int OUT_WID = psum_acc_buf_pkg::OFMAP_WID
) (
    input  logic signed [ACC_WID-1:0] acc_i,
    output logic signed [OUT_WID-1:0] q_o
);

    localparam logic signed [ACC_WID-1:0] Q_MAX = ACC_WID'((1 << (OUT_WID - 1)) - 1);
    localparam logic signed [ACC_WID-1:0] Q_MIN = ~Q_MAX;

    logic signed [ACC_WID-1:0] shifted;
    logic signed [OUT_WID-1:0] sat;

    always_comb begin
        shifted = acc_i >>> SHIFT;
        if (shifted > Q_MAX) begin
            sat = Q_MAX[OUT_WID-1:0];
        end else if (shifted < Q_MIN) begin
            sat = Q_MIN[OUT_WID-1:0];
        end else begin
            sat = shifted[OUT_WID-1:0];
        end
`ifdef PSUM_ACC_RELU_EN
        q_o = sat[OUT_WID-1] ? '0 : sat;
`else
        q_o = sat;
`endif
    end

endmodule

// File: rtl/psum_acc_buf.sv
// psum_acc_buf: accumulates NUM_CH passes of DEPTH partial sums from one
// PE_vec row, then requantizes and drains DEPTH ofmap values over
// valid/ready. group_done pulses after the last drain handshake.
// Optional ReLU in the requantizer: define PSUM_ACC_RELU_EN.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous abort of the current group
//   bus    : psum_acc_buf_if.slave (psum in, ofmap out, group_done)
//
// state    | meaning
// ST_ACCUM | accepting psums, overwrite on pass 0, accumulate after
// ST_DRAIN | presenting requantized entries, psum_ready low

module psum_acc_buf #(
    parameter int PSUM_WID = psum_acc_buf_pkg::PSUM_WID,
    parameter int ACC_WID  = psum_acc_buf_pkg::ACC_WID,
    parameter int OUT_WID  = psum_acc_buf_pkg::OFMAP_WID,
    parameter int DEPTH    = 8,
    parameter int NUM_CH   = 3,
    parameter int SHIFT    = 0
) (
    input logic           clk_i,
    input logic           rst_ni,
    input logic           clr_i,
    psum_acc_buf_if.slave bus
);
    import psum_acc_buf_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d, rd_nxt;
    logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
    logic                      psum_ready_q, psum_ready_d;
    logic signed [OUT_WID-1:0] ofmap_q, ofmap_d, q_res;
    logic                      ofmap_valid_q, ofmap_valid_d;
    logic                      group_done_q, group_done_d;
    logic signed [ACC_WID-1:0] acc_mem_q [DEPTH];
    logic signed [ACC_WID-1:0] psum_ext, acc_new, q_src;
    logic                      accept;

    // psum_ready_q is only high in ST_ACCUM, so it also qualifies the state.
    assign accept   = psum_ready_q & bus.psum_valid & ~clr_i;
    assign psum_ext = {{(ACC_WID - PSUM_WID){bus.psum_in[PSUM_WID-1]}}, bus.psum_in};
    assign acc_new  = (ch_cnt_q == '0) ? psum_ext : acc_mem_q[wr_idx_q] + psum_ext;
    assign rd_nxt   = rd_idx_q + 1'b1;

    // Requantizer source: the next entry while draining; on the final
    // accept entry 0 is loaded, bypassing the write when it is the entry
    // being written this cycle (DEPTH == 1).
    always_comb begin
        if (state_q == ST_DRAIN) begin
            q_src = acc_mem_q[rd_nxt];
        end else if (wr_idx_q == '0) begin
            q_src = acc_new;
        end else begin
            q_src = acc_mem_q[0];
        end
    end

    psum_quant #(
        .ACC_WID (ACC_WID),
        .SHIFT   (SHIFT),
        .OUT_WID (OUT_WID)
    ) u_quant (
        .acc_i (q_src),
        .q_o   (q_res)
    );

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        ch_cnt_d      = ch_cnt_q;
        rd_idx_d      = rd_idx_q;
        ofmap_d       = ofmap_q;
        ofmap_valid_d = ofmap_valid_q;
        group_done_d  = 1'b0;
        if (clr_i) begin
            state_d       = ST_ACCUM;
            wr_idx_d      = '0;
            ch_cnt_d      = '0;
            rd_idx_d      = '0;
            ofmap_d       = '0;
            ofmap_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_d = '0;
                            if (ch_cnt_q == LAST_CH) begin
                                ch_cnt_d      = '0;
                                state_d       = ST_DRAIN;
                                ofmap_d       = q_res;
                                ofmap_valid_d = 1'b1;
                            end else begin
                                ch_cnt_d = ch_cnt_q + 1'b1;
                            end
                        end else begin
                            wr_idx_d = wr_idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ofmap_valid_q && bus.ofmap_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_d      = '0;
                            state_d       = ST_ACCUM;
                            ofmap_d       = '0;
                            ofmap_valid_d = 1'b0;
                            group_done_d  = 1'b1;
                        end else begin
                            rd_idx_d = rd_nxt;
                            ofmap_d  = q_res;
                        end
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    assign psum_ready_d = (state_d == ST_ACCUM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_ACCUM;
            wr_idx_q      <= '0;
            ch_cnt_q      <= '0;
            rd_idx_q      <= '0;
            psum_ready_q  <= 1'b0;
            ofmap_q       <= '0;
            ofmap_valid_q <= 1'b0;
            group_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            ch_cnt_q      <= ch_cnt_d;
            rd_idx_q      <= rd_idx_d;
            psum_ready_q  <= psum_ready_d;
            ofmap_q       <= ofmap_d;
            ofmap_valid_q <= ofmap_valid_d;
            group_done_q  <= group_done_d;
        end
    end

    // No reset on the buffer: pass 0 of every group overwrites each entry.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc_mem_q[wr_idx_q] <= acc_new;
        end
    end

    assign bus.psum_ready  = psum_ready_q;
    assign bus.ofmap_out   = ofmap_q;
    assign bus.ofmap_valid = ofmap_valid_q;
    assign bus.group_done  = group_done_q;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Testbench for psum_acc_buf. Three instances share the clock and reset:
//   dut 0 : NUM_CH=3, DEPTH=4, SHIFT=0
//   dut 1 : NUM_CH=1, DEPTH=4, SHIFT=0
//   dut 2 : NUM_CH=1, DEPTH=4, SHIFT=1
// Inputs are driven and outputs sampled on the falling edge.

module tb_psum_acc_buf;

    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0]        clr_v, pv_v, ordy_v;
    logic signed [15:0] pin_v [3];
    logic [2:0]        prdy_v, ov_v, gd_v;
    logic signed [7:0]  oo_v [3];

    psum_acc_buf_if #(.PSUM_WID(16), .OUT_WID(8)) bif0 ();
    psum_acc_buf_if #(.PSUM_WID(16), .OUT_WID(8)) bif1 ();
    psum_acc_buf_if #(.PSUM_WID(16), .OUT_WID(8)) bif2 ();

    assign bif0.psum_in = pin_v[0];
    assign bif1.psum_in = pin_v[1];
    assign bif2.psum_in = pin_v[2];
    assign bif0.psum_valid = pv_v[0];
    assign bif1.psum_valid = pv_v[1];
    assign bif2.psum_valid = pv_v[2];
    assign bif0.ofmap_ready = ordy_v[0];
    assign bif1.ofmap_ready = ordy_v[1];
    assign bif2.ofmap_ready = ordy_v[2];
    assign prdy_v = {bif2.psum_ready, bif1.psum_ready, bif0.psum_ready};
    assign ov_v   = {bif2.ofmap_valid, bif1.ofmap_valid, bif0.ofmap_valid};
    assign gd_v   = {bif2.group_done, bif1.group_done, bif0.group_done};
    assign oo_v[0] = bif0.ofmap_out;
    assign oo_v[1] = bif1.ofmap_out;
    assign oo_v[2] = bif2.ofmap_out;

    psum_acc_buf #(.PSUM_WID(16), .ACC_WID(24), .OUT_WID(8), .DEPTH(DEP), .NUM_CH(3), .SHIFT(0))
        u_dut0 (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr_v[0]), .bus(bif0.slave));
    psum_acc_buf #(.PSUM_WID(16), .ACC_WID(24), .OUT_WID(8), .DEPTH(DEP), .NUM_CH(1), .SHIFT(0))
        u_dut1 (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr_v[1]), .bus(bif1.slave));
    psum_acc_buf #(.PSUM_WID(16), .ACC_WID(24), .OUT_WID(8), .DEPTH(DEP), .NUM_CH(1), .SHIFT(1))
        u_dut2 (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr_v[2]), .bus(bif2.slave));

    function automatic int nch(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int shf(input int d);
        return (d == 2) ? 1 : 0;
    endfunction

    // Reference requantizer: floor shift, clamp to int8, optional ReLU.
    function automatic int quant(input int acc, input int sh);
        int t;
        t = acc >>> sh;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
`ifdef PSUM_ACC_RELU_EN
        if (t < 0) t = 0;
`endif
        return t;
    endfunction

    // Expected ofmap per position: sum over passes, wrapped to 24 bits.
    task automatic build_exp(input int d, input int vals[$], output int exp_q[$]);
        longint s;
        exp_q = {};
        for (int p = 0; p < DEP; p++) begin
            s = 0;
            for (int c = 0; c < nch(d); c++) s += vals[c*DEP + p];
            s = (s <<< 40) >>> 40;
            exp_q.push_back(quant(int'(s), shf(d)));
        end
    endtask

    task automatic rand_vals(input int d, output int vals[$]);
        vals = {};
        for (int k = 0; k < DEP * nch(d); k++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
    endtask

    // Called on a falling edge; returns on the falling edge after the last accept.
    task automatic feed(input int d, input int vals[$], input bit rnd_valid, input string tag);
        int idx = 0;
        int cyc = 0;
        while (idx < vals.size()) begin
            total++;
            if (prdy_v[d] !== 1'b1 || ov_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s feed[%0d]: psum_ready=%0b ofmap_valid=%0b want 1/0", tag, idx, prdy_v[d], ov_v[d]);
            end
            pv_v[d]  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            pin_v[d] = 16'(vals[idx]);
            if (pv_v[d]) idx++;
            @(negedge clk);
            if (++cyc > 300) begin
                total++; bad++;
                $display("FAIL %s feed timeout: accepted %0d want %0d", tag, idx, vals.size());
                break;
            end
        end
    endtask

    // Called on the falling edge right after the final accept.
    task automatic drain(input int d, input int exp_q[$], input int stall, input bit rnd_ready,
                         input bit b2b, input string tag);
        int i = 0;
        int cyc = 0;
        int st = stall;
        total++;
        if (ov_v[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: ofmap_valid=%0b want 1", tag, ov_v[d]);
        end
        while (i < exp_q.size()) begin
            total++;
            if (ov_v[d] !== 1'b1 || oo_v[d] !== 8'(exp_q[i])) begin
                bad++;
                $display("FAIL %s out[%0d]: got %0d valid=%0b want %0d", tag, i, oo_v[d], ov_v[d], exp_q[i]);
            end
            total++;
            if (prdy_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s drain psum_ready: got %0b want 0", tag, prdy_v[d]);
            end
            pv_v[d]  = 1'b1;
            pin_v[d] = 16'($urandom);
            if (st > 0) begin
                ordy_v[d] = 1'b0;
                st--;
            end else begin
                ordy_v[d] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ordy_v[d]) i++;
            @(negedge clk);
            if (++cyc > 300) begin
                total++; bad++;
                $display("FAIL %s drain timeout: got %0d outputs want %0d", tag, i, exp_q.size());
                break;
            end
        end
        total++;
        if (ov_v[d] !== 1'b0 || gd_v[d] !== 1'b1 || prdy_v[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s end: valid=%0b done=%0b psum_ready=%0b want 0/1/1", tag, ov_v[d], gd_v[d], prdy_v[d]);
        end
        pv_v[d] = 1'b0;
        if (!b2b) begin
            @(negedge clk);
            total++;
            if (gd_v[d] !== 1'b0 || ov_v[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s done pulse: done=%0b valid=%0b want 0/0", tag, gd_v[d], ov_v[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        clr_v  = '0;
        pv_v   = '0;
        ordy_v = '0;
        for (int d = 0; d < 3; d++) pin_v[d] = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (prdy_v[d] !== 1'b0 || ov_v[d] !== 1'b0 || gd_v[d] !== 1'b0 || oo_v[d] !== 8'sd0) begin
                bad++;
                $display("FAIL reset dut%0d: ready=%0b valid=%0b done=%0b out=%0d want 0", d, prdy_v[d], ov_v[d], gd_v[d], oo_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (prdy_v[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset release dut%0d: psum_ready=%0b want 1", d, prdy_v[d]);
            end
        end
    endtask

    task automatic test_accum();
        int v[$];
        int e[$];
        v = '{10, -5, 100, 7, 1, 2, 3, 4, -1, -1, -1, -1};
        build_exp(0, v, e);
        feed(0, v, 1'b0, "accum");
        drain(0, e, 0, 1'b0, 1'b0, "accum");
    endtask

    task automatic test_saturation();
        int v[$];
        int e[$];
        v = '{300, -300, 127, -7};
        for (int d = 1; d < 3; d++) begin
            build_exp(d, v, e);
            feed(d, v, 1'b0, "sat");
            drain(d, e, 0, 1'b0, 1'b0, (d == 1) ? "sat_shift0" : "sat_shift1");
        end
    endtask

    task automatic test_backpressure();
        int v[$];
        int e[$];
        v = '{10, -5, 100, 7, 1, 2, 3, 4, -1, -1, -1, -1};
        build_exp(0, v, e);
        feed(0, v, 1'b1, "bp");
        drain(0, e, 3, 1'b1, 1'b0, "bp");
    endtask

    task automatic test_clr();
        int v[$];
        int part[$];
        int e[$];
        v = '{10, -5, 100, 7, 1, 2, 3, 4, -1, -1, -1, -1};
        build_exp(0, v, e);
        part = v[0:4];
        feed(0, part, 1'b0, "clr_part");
        clr_v[0] = 1'b1;
        pv_v[0]  = 1'b1;
        pin_v[0] = 16'sd999;
        @(negedge clk);
        clr_v[0] = 1'b0;
        total++;
        if (prdy_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL clr accum: psum_ready=%0b valid=%0b want 1/0", prdy_v[0], ov_v[0]);
        end
        feed(0, v, 1'b1, "clr_rerun");
        drain(0, e, 0, 1'b0, 1'b0, "clr_rerun");

        // abort during drain after one handshake
        feed(0, v, 1'b0, "clr_drain");
        total++;
        if (ov_v[0] !== 1'b1 || oo_v[0] !== 8'(e[0])) begin
            bad++;
            $display("FAIL clr drain first: got %0d valid=%0b want %0d", oo_v[0], ov_v[0], e[0]);
        end
        ordy_v[0] = 1'b1;
        @(negedge clk);
        total++;
        if (oo_v[0] !== 8'(e[1])) begin
            bad++;
            $display("FAIL clr drain second: got %0d want %0d", oo_v[0], e[1]);
        end
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        total++;
        if (ov_v[0] !== 1'b0 || gd_v[0] !== 1'b0 || prdy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL clr drain abort: valid=%0b done=%0b ready=%0b want 0/0/1", ov_v[0], gd_v[0], prdy_v[0]);
        end
        feed(0, v, 1'b0, "clr_after_drain");
        drain(0, e, 0, 1'b0, 1'b0, "clr_after_drain");
    endtask

    task automatic test_reset_drain();
        int v[$];
        int e[$];
        v = '{10, -5, 100, 7, 1, 2, 3, 4, -1, -1, -1, -1};
        build_exp(0, v, e);
        feed(0, v, 1'b0, "rst_drain");
        rst_n = 1'b0;
        #1;
        total++;
        if (ov_v[0] !== 1'b0 || oo_v[0] !== 8'sd0 || gd_v[0] !== 1'b0 || prdy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst drain: valid=%0b out=%0d done=%0b ready=%0b want 0", ov_v[0], oo_v[0], gd_v[0], prdy_v[0]);
        end
        pv_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (prdy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst drain release: psum_ready=%0b want 1", prdy_v[0]);
        end
        feed(0, v, 1'b0, "rst_rerun");
        drain(0, e, 0, 1'b0, 1'b0, "rst_rerun");
    endtask

    task automatic test_back_to_back();
        int va[$];
        int vb[$];
        int ea[$];
        int eb[$];
        rand_vals(0, va);
        rand_vals(0, vb);
        build_exp(0, va, ea);
        build_exp(0, vb, eb);
        feed(0, va, 1'b0, "b2b_a");
        drain(0, ea, 0, 1'b0, 1'b1, "b2b_a");
        feed(0, vb, 1'b0, "b2b_b");
        drain(0, eb, 0, 1'b0, 1'b0, "b2b_b");
    endtask

    task automatic test_random();
        int v[$];
        int e[$];
        for (int d = 0; d < 3; d++) begin
            for (int g = 0; g < 3; g++) begin
                rand_vals(d, v);
                build_exp(d, v, e);
                feed(d, v, 1'b1, "rand");
                drain(d, e, 0, 1'b1, 1'b0, "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_accum();
        test_saturation();
        test_backpressure();
        test_clr();
        test_reset_drain();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_acc_buf.md
Name: psum_acc_buf

Overview:
- Downstream neighbour of the PE_vec row datapath. It consumes the `psum` stream of one PE_vec row.
- Accumulates partial sums over NUM_CH input-channel passes into a DEPTH-entry buffer, one entry per output position.
- After the last pass it requantizes each entry (arithmetic shift plus saturation) and drains the results as ofmap values over a valid/ready handshake to the ofmap writeback stage.

Parameters:
- PSUM_WID, 16, width of incoming signed psum; tied to `psum_wid at instantiation.
- ACC_WID, 24, signed accumulator width; must be ≥ PSUM_WID + clog2(NUM_CH).
- OUT_WID, 8, signed ofmap output width.
- DEPTH, 8, output positions per pass (buffer entries).
- NUM_CH, 3, channel passes per accumulation group; must be ≥ 1.
- SHIFT, 0, arithmetic right shift applied before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: discard the group and return to ACCUM.
- psum_in  in  PSUM_WID  signed partial sum from PE_vec.
- psum_valid  in  1  psum_in valid.
- psum_ready  out  1  block can accept psum.
- ofmap_out  out  OUT_WID  signed requantized result.
- ofmap_valid  out  1  ofmap_out valid.
- ofmap_ready  in  1  downstream accepts.
- group_done  out  1  one-cycle pulse after the last drain handshake.

Behaviour:
- Reset (rst=0, async):
  - state=ACCUM; wr_idx=0, ch_cnt=0, rd_idx=0.
  - psum_ready=0 while rst is low, then 1 in the first cycle after release.
  - ofmap_out=0, ofmap_valid=0, group_done=0.
  - Buffer contents are not cleared; the first pass overwrites them.
- States: ACCUM, DRAIN.
- ACCUM:
  - psum_ready=1, ofmap_valid=0.
  - Accept when psum_valid & psum_ready.
  - ch_cnt==0: buf[wr_idx] ← sign-extend(psum_in).
  - ch_cnt>0: buf[wr_idx] ← buf[wr_idx] + sign-extend(psum_in), in ACC_WID with two's-complement wrap and no overflow detection.
  - After each accept wr_idx increments. When wr_idx wraps DEPTH-1→0, ch_cnt increments.
  - Accept of (wr_idx=DEPTH-1, ch_cnt=NUM_CH-1) → DRAIN next cycle, with ch_cnt=0 and wr_idx=0.
  - The final accumulated value must be visible to the drain; a write-through bypass is allowed.
- DRAIN:
  - psum_ready=0.
  - ofmap_valid rises in the cycle after the final accept, carrying entry 0 (registered output, latency 1).
  - On ofmap_valid & ofmap_ready: rd_idx increments and ofmap_out loads the next entry in the next cycle; ofmap_valid stays high.
  - While ofmap_ready=0: ofmap_out and ofmap_valid are held stable.
  - Handshake on rd_idx=DEPTH-1: next cycle ofmap_valid=0, group_done=1 for one cycle, state=ACCUM, psum_ready=1, rd_idx=0.
- Requantize, per entry:
  - t = buf >>> SHIFT, arithmetic shift, floor toward −inf.
  - Saturate t to [−2^(OUT_WID−1), 2^(OUT_WID−1)−1].
- clr:
  - In any state, next cycle: state=ACCUM, all counters 0, ofmap_valid=0, group_done=0.
  - A psum presented in the same cycle as clr is dropped.
  - clr during DRAIN discards the remaining outputs.
- Simultaneous events:
  - psum_valid during DRAIN is ignored; the upstream holds it because psum_ready=0.
  - NUM_CH=1: the first pass goes directly to DRAIN.

Optional Feature:
- Macro PSUM_ACC_RELU_EN.
- Defined: after saturation, negative values are output as 0 (ReLU fused into requantize).
- Undefined: signed saturated values pass unchanged.
- The buffer contents are identical either way.

Decomposition:
- Shared package/header holds the width defines (`ifmap_wid, `weight_wid, `psum_wid) plus new `acc_wid and `ofmap_wid, and the state encoding constants ST_ACCUM and ST_DRAIN.
- One combinational sub-module, psum_quant: input ACC_WID, parameters SHIFT and OUT_WID, output OUT_WID. It performs shift, saturation and the optional ReLU, and is reused by later pooling/writeback stages.

Test Plan:
1. Accumulation, NUM_CH=3, DEPTH=4, SHIFT=0, ofmap_ready=1:
   - Passes [10,−5,100,7], [1,2,3,4], [−1,−1,−1,−1].
   - Expect outputs 10, −4, 102, 10 on 4 consecutive cycles, ofmap_valid first one cycle after the 12th accept, then group_done for one cycle.
2. Saturation and shift:
   - Single pass (NUM_CH=1) of [300, −300, 127, −7], SHIFT=0 → 127, −128, 127, −7.
   - Same pass with SHIFT=1 → 127 (150 saturated), −128 (−150 saturated), 63, −4.
3. Backpressure:
   - Hold ofmap_ready=0 for 3 cycles while ofmap_valid is high.
   - ofmap_out stays 10 and psum_ready stays 0; the remaining outputs come out in order once ofmap_ready rises.
4. Reset/clr mid-operation:
   - Assert clr after 5 of 12 accepts; rerun scenario 1 in full → outputs exactly 10, −4, 102, 10.
   - Drop rst to 0 during DRAIN → all outputs 0 immediately; after release, psum_ready=1.
5. PSUM_ACC_RELU_EN defined:
   - Scenario 1 → 10, 0, 102, 10.
   - Scenario 2 (SHIFT=0) → 127, 0, 127, 0.
6. Back-to-back groups: run two groups with no idle cycles between them → psum_ready re-asserts in the same cycle group_done pulses, and the second group's first pass overwrites stale entries.
